// File: rtl/zoom_pkg.sv
// zoom_pkg: shared encodings for the image-scaling sequencer.
//   modo_e  - operation mode (copy, nearest-neighbour zoom-in, decimating zoom-out)
//   fator_e - scale factor, encoded as a shift amount (x1/x2/x4)
//   state_e - sequencer FSM states
//   cmd_legal() - command screening used while idle
package zoom_pkg;

  typedef enum logic [1:0] {
    MODO_COPIA = 2'd0,
    MODO_IN    = 2'd1,
    MODO_OUT   = 2'd2
  } modo_e;

  typedef enum logic [1:0] {
    F1 = 2'd0,
    F2 = 2'd1,
    F4 = 2'd2
  } fator_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIM
  } state_e;

  localparam logic [1:0] MODO_RSV  = 2'd3;
  localparam logic [1:0] FATOR_RSV = 2'd3;

  // Copy only makes sense at x1; both code 3 values are reserved.
  function automatic logic cmd_legal(input logic [1:0] m, input logic [1:0] f);
    return !((m == MODO_RSV) || (f == FATOR_RSV) ||
             ((m == MODO_COPIA) && (f != F1)));
  endfunction

endpackage

// File: rtl/zoom_ctrl_if.sv
// zoom_ctrl_if: pixel-memory bus between the sequencer and the two external
// synchronous RAMs (1-cycle read latency on the source side).
//   src_rd_en/src_addr -> source read request; src_data <- pixel, next cycle
//   dst_wr_en/dst_addr/dst_data -> destination write
// master: sequencer side; slave: memory side.
interface zoom_ctrl_if #(
  parameter int SRC_AW = 15,
  parameter int DST_AW = 19
);
  logic              src_rd_en;
  logic [SRC_AW-1:0] src_addr;
  logic [7:0]        src_data;
  logic              dst_wr_en;
  logic [DST_AW-1:0] dst_addr;
  logic [7:0]        dst_data;

  modport master (
    output src_rd_en, src_addr, dst_wr_en, dst_addr, dst_data,
    input  src_data
  );

  modport slave (
    input  src_rd_en, src_addr, dst_wr_en, dst_addr, dst_data,
    output src_data
  );
endinterface

// File: rtl/zoom_addr_gen.sv
// zoom_addr_gen: raster x/y counter over a W x H image, x fastest.
//   clock, reset (sync, active-low)
//   clr  - return to (0,0)
//   en   - advance one pixel
//   w, h - run-time image size
//   x, y - current coordinate; last - current coordinate is (w-1, h-1)
module zoom_addr_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [11:0] w,
  input  logic [11:0] h,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        last
);

  logic x_end;

  assign x_end = (x == w - 12'd1);
  assign last  = x_end && (y == h - 12'd1);

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_end) begin
        x <= '0;
        y <= y + 12'd1;
      end else begin
        x <= x + 12'd1;
      end
    end
  end

endmodule

// File: rtl/zoom_ctrl.sv
// zoom_ctrl: sequencer for the image-scaling datapath. Walks the destination
// image in raster order at one pixel per cycle, reading the source pixel that
// maps onto each destination pixel and writing it one cycle later.
//   clock, reset (sync, active-low)
//   start/modo/fator - command, sampled only in IDLE
//   busy, done, erro - status (done/erro are one-cycle pulses)
//   out_largura/out_altura - output dimensions latched at an accepted start
//   mem - source-read / destination-write bus
module zoom_ctrl
  import zoom_pkg::*;
#(
  parameter int largura = 160,
  parameter int altura  = 120,
  parameter int SRC_AW  = $clog2(largura * altura),
  parameter int DST_AW  = $clog2(16 * largura * altura)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  modo,
  input  logic [1:0]  fator,
  output logic        busy,
  output logic        done,
  output logic        erro,
  output logic [11:0] out_largura,
  output logic [11:0] out_altura,
  zoom_ctrl_if.master mem
);

  localparam logic [11:0]       LARG12 = 12'(largura);
  localparam logic [11:0]       ALT12  = 12'(altura);
  localparam logic [SRC_AW-1:0] LARG_S = SRC_AW'(largura);

  state_e            state_q, state_d;
  modo_e             modo_q;
  logic [1:0]        shift_q;
  logic [11:0]       w_d, h_d;
  logic              accept, erro_d, erro_q;
  logic              rd_en, wr_en_q, last;
  logic [11:0]       x, y, sx, sy;
  logic [DST_AW-1:0] dst_idx_q, dst_addr_q;

  // Output dimensions for the command currently on the inputs.
  always_comb begin
    w_d = LARG12;
    h_d = ALT12;
    if (modo == MODO_IN) begin
      w_d = LARG12 << fator;
      h_d = ALT12 << fator;
    end else if (modo == MODO_OUT) begin
      w_d = LARG12 >> fator;
      h_d = ALT12 >> fator;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    erro_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd_legal(modo, fator)) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   state_d = FIM;
      FIM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      modo_q      <= MODO_COPIA;
      shift_q     <= '0;
      out_largura <= '0;
      out_altura  <= '0;
      erro_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      dst_idx_q   <= '0;
      dst_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      erro_q  <= erro_d;
      wr_en_q <= rd_en;
      if (accept) begin
        modo_q      <= modo_e'(modo);
        shift_q     <= fator;
        out_largura <= w_d;
        out_altura  <= h_d;
        dst_idx_q   <= '0;
      end else if (rd_en) begin
        dst_idx_q <= dst_idx_q + DST_AW'(1);
      end
      if (rd_en) dst_addr_q <= dst_idx_q;
    end
  end

  zoom_addr_gen u_gen (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    (rd_en),
    .w     (out_largura),
    .h     (out_altura),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  // Destination walk is strictly raster, so y*W + x is just a running pixel
  // index; this avoids a run-time multiply by W.
  always_comb begin
    if (modo_q == MODO_OUT) begin
      sx = x << shift_q;
      sy = y << shift_q;
    end else begin
      sx = x >> shift_q;
      sy = y >> shift_q;
    end
  end

  assign rd_en = (state_q == RUN);
  assign busy  = (state_q == RUN) || (state_q == DRAIN);
  assign done  = (state_q == FIM);
  assign erro  = erro_q;

  assign mem.src_rd_en = rd_en;
  assign mem.src_addr  = rd_en ? (SRC_AW'(sy) * LARG_S + SRC_AW'(sx)) : '0;
  // Write stage lines up with the RAM's 1-cycle read data.
  assign mem.dst_wr_en = wr_en_q;
  assign mem.dst_addr  = dst_addr_q;
  assign mem.dst_data  = wr_en_q ? mem.src_data : '0;

endmodule

// File: tb/tb_zoom_ctrl.sv
module tb_zoom_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, sel;
  logic [1:0] modo, fator;
  logic       start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  // DUT A: 2x2 source; DUT B: 4x4 source
  logic        a_busy, a_done, a_erro, b_busy, b_done, b_erro;
  logic [11:0] a_ow, a_oh, b_ow, b_oh;

  zoom_ctrl_if #(.SRC_AW(2), .DST_AW(6)) bus_a ();
  zoom_ctrl_if #(.SRC_AW(4), .DST_AW(8)) bus_b ();

  zoom_ctrl #(.largura(2), .altura(2), .SRC_AW(2), .DST_AW(6)) u_a (
    .clock(clk), .reset(reset), .start(start_a), .modo(modo), .fator(fator),
    .busy(a_busy), .done(a_done), .erro(a_erro),
    .out_largura(a_ow), .out_altura(a_oh), .mem(bus_a));

  zoom_ctrl #(.largura(4), .altura(4), .SRC_AW(4), .DST_AW(8)) u_b (
    .clock(clk), .reset(reset), .start(start_b), .modo(modo), .fator(fator),
    .busy(b_busy), .done(b_done), .erro(b_erro),
    .out_largura(b_ow), .out_altura(b_oh), .mem(bus_b));

  // Source RAMs with 1-cycle read latency
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [16];
  always @(posedge clk) if (bus_a.src_rd_en) bus_a.src_data <= mem_a[bus_a.src_addr];
  always @(posedge clk) if (bus_b.src_rd_en) bus_b.src_data <= mem_b[bus_b.src_addr];

  // View of the selected DUT
  logic        o_busy, o_done, o_erro, o_rd, o_wr;
  logic [11:0] o_w, o_h;
  logic [7:0]  o_daddr, o_data;
  always_comb begin
    if (sel) begin
      o_busy = b_busy; o_done = b_done; o_erro = b_erro; o_w = b_ow; o_h = b_oh;
      o_rd = bus_b.src_rd_en; o_wr = bus_b.dst_wr_en;
      o_daddr = bus_b.dst_addr; o_data = bus_b.dst_data;
    end else begin
      o_busy = a_busy; o_done = a_done; o_erro = a_erro; o_w = a_ow; o_h = a_oh;
      o_rd = bus_a.src_rd_en; o_wr = bus_a.dst_wr_en;
      o_daddr = 8'(bus_a.dst_addr); o_data = bus_a.dst_data;
    end
  end

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int exp_addr[$];
  int exp_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Pushes the expected destination image into the scoreboard, issues the
  // command and checks every write, the done timing and the counts.
  task automatic run_op(input logic s, input logic [1:0] m, input logic [1:0] f,
                        input int spam, input int abort_at);
    int L, A, W, H, N, sx, sy, x, y, d, wcount, rcount, done_n;
    logic prev_rd;
    logic aborted;
    L = s ? 4 : 2;
    A = L;
    W = (m == 2'd1) ? (L << f) : (m == 2'd2) ? (L >> f) : L;
    H = (m == 2'd1) ? (A << f) : (m == 2'd2) ? (A >> f) : A;
    N = W * H;
    for (int i = 0; i < N; i++) begin
      x = i % W;
      y = i / W;
      if (m == 2'd2) begin sx = x << f; sy = y << f; end
      else           begin sx = x >> f; sy = y >> f; end
      d = s ? int'(mem_b[sy * L + sx]) : int'(mem_a[sy * L + sx]);
      exp_addr.push_back(i);
      exp_data.push_back(d);
    end
    wcount = 0; rcount = 0; done_n = -1; prev_rd = 1'b0; aborted = 1'b0;
    @(negedge clk);
    sel = s; modo = m; fator = f; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= N + 8; n++) begin
      @(negedge clk);
      start = (spam != 0) && (n >= 2) && (n <= 8) && (n % 2 == 0);
      if (n == 1) begin
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("out_largura", 32'(o_w), 32'(W));
        chk("out_altura", 32'(o_h), 32'(H));
      end
      if (o_rd) rcount++;
      if (o_wr) begin
        chk("wr_follows_rd", 32'(prev_rd), 32'd1);
        if (exp_addr.size() == 0) begin
          chk("extra_write", 32'd1, 32'd0);
        end else begin
          chk("dst_addr", 32'(o_daddr), 32'(exp_addr.pop_front()));
          chk("dst_data", 32'(o_data), 32'(exp_data.pop_front()));
        end
        wcount++;
        if (wcount == abort_at) begin
          reset = 1'b0;
          aborted = 1'b1;
          break;
        end
      end
      prev_rd = o_rd;
      if (o_done) begin
        done_n = n;
        chk("busy_at_done", 32'(o_busy), 32'd0);
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk("abort_no_write", 32'(o_wr), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_no_read", 32'(o_rd), 32'd0);
      end
      reset = 1'b1;
      exp_addr.delete();
      exp_data.delete();
    end else begin
      chk("done_cycle", 32'(done_n), 32'(N + 2));
      chk("write_count", 32'(wcount), 32'(N));
      chk("read_count", 32'(rcount), 32'(N));
      chk("scoreboard_empty", 32'(exp_addr.size()), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(o_done), 32'd0);
    end
  endtask

  task automatic err_cmd(input logic [1:0] m, input logic [1:0] f);
    @(negedge clk);
    sel = 1'b1; modo = m; fator = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("erro_pulse", 32'(o_erro), 32'd1);
    chk("erro_busy", 32'(o_busy), 32'd0);
    chk("erro_no_read", 32'(o_rd), 32'd0);
    chk("erro_no_write", 32'(o_wr), 32'd0);
    @(negedge clk);
    chk("erro_one_cycle", 32'(o_erro), 32'd0);
    chk("erro_idle_busy", 32'(o_busy), 32'd0);
    chk("erro_idle_read", 32'(o_rd), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sel = 1'b0; modo = 2'd0; fator = 2'd0;
    mem_a[0] = 8'd2; mem_a[1] = 8'd4; mem_a[2] = 8'd7; mem_a[3] = 8'd9;
    for (int i = 0; i < 16; i++) mem_b[i] = 8'(i);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_erro", 32'(o_erro), 32'd0);
      chk("rst_w", 32'(o_w), 32'd0);
      chk("rst_h", 32'(o_h), 32'd0);
      chk("rst_rd", 32'(o_rd), 32'd0);
      chk("rst_wr", 32'(o_wr), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
    end
    reset = 1'b1;

    run_op(1'b0, 2'd1, 2'd1, 0, 0);   // zoom-in x2, 2x2
    run_op(1'b1, 2'd2, 2'd1, 0, 0);   // zoom-out x2, 4x4
    run_op(1'b1, 2'd0, 2'd0, 0, 0);   // copy, 4x4

    err_cmd(2'd3, 2'd0);
    err_cmd(2'd1, 2'd3);
    err_cmd(2'd0, 2'd1);

    for (int i = 0; i < 16; i++) mem_b[i] = 8'((i * 13 + 5) & 255);
    run_op(1'b1, 2'd1, 2'd2, 0, 10);  // zoom-in x4, reset at 10th write
    chk("post_abort_w", 32'(o_w), 32'd0);
    run_op(1'b1, 2'd1, 2'd2, 0, 0);   // full zoom-in x4
    run_op(1'b0, 2'd1, 2'd1, 1, 0);   // start spam during RUN

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
